// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage. Holds the fetch PC, issues word-addressed requests
// to instruction memory, and buffers the in-order responses in a small FIFO.
// It presents instruction/PC pairs to decode over a valid/ready handshake.
// A redirect (taken branch/jump target) restarts fetch at redirect_pc. It also
// discards everything that is buffered or still in flight.
//
// Optional feature: define FETCH_PERF_EN to build the 32-bit performance
// counters. Without it, perf_fetched and perf_dropped are tied to 0.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   redirect_valid/pc : redirect request and new fetch PC
//   imem_req/addr     : fetch request and word address (combinational)
//   imem_gnt          : request accepted when imem_req & imem_gnt
//   imem_rvalid/rdata : in-order response, latency >= 1
//   if_valid/ready    : decode handshake
//   if_instr/if_pc    : FIFO head instruction and its address (0 when empty)
//   perf_fetched      : instructions delivered to decode
//   perf_dropped      : responses discarded by a flush
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int              PC_W     = 36,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_d [DEPTH];
  logic [PC_W-1:0]    fifo_pc_q    [DEPTH];
  logic [PC_W-1:0]    fifo_pc_d    [DEPTH];

  logic [CNT_W-1:0]   live;
  logic [CNT_W:0]     credit_used;
  logic               fifo_empty;
  logic               grant;
  logic               pop;
  logic               push;
  logic               drop_resp;

  // Requests still owed to the current fetch stream. These plus the buffered
  // entries must fit in the FIFO, so a response can never find it full.
  assign live        = outstanding_q - drop_cnt_q;
  assign credit_used = {1'b0, fifo_count_q} + {1'b0, live};
  assign fifo_empty  = (fifo_count_q == '0);

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = (state_q != ST_BOOT) && !redirect_valid &&
                (credit_used < (CNT_W+1)'(DEPTH)) &&
                (outstanding_q < CNT_W'(DEPTH));
    imem_addr = fetch_pc_q;
    if_valid  = !fifo_empty && !redirect_valid;
    if_instr  = fifo_empty ? '0 : fifo_instr_q[rd_ptr_q];
    if_pc     = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
  end

  assign grant     = imem_req && imem_gnt;
  assign pop       = if_valid && if_ready;
  // A response is stale if it arrives during a redirect or while drops remain.
  assign drop_resp = imem_rvalid && (redirect_valid || (drop_cnt_q != '0));
  assign push      = imem_rvalid && !drop_resp;

  // ---------------------------------------------------------------------------
  // Datapath / counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_count_d  = fifo_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);

    if (redirect_valid) begin
      // Everything in flight now belongs to the old stream, except a response
      // landing this cycle (it is dropped immediately).
      fetch_pc_d   = redirect_pc;
      resp_pc_d    = redirect_pc;
      drop_cnt_d   = outstanding_q - CNT_W'(imem_rvalid);
      fifo_count_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
      if (drop_resp) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        resp_pc_d              = resp_pc_q + PC_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:           state_d = ST_RUN;
      ST_RUN, ST_FLUSH:  state_d = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
      default:           state_d = ST_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_dropped_d = perf_dropped_q + 32'(drop_resp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  assign perf_fetched = '0;
  assign perf_dropped = '0;
`endif

  // A response with nothing outstanding is a protocol error by the memory.
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding_q == '0)));

  // The credit rule keeps a push from ever meeting a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_count_q == CNT_W'(DEPTH)) && !pop));

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam int              PC_W     = 36;
  localparam int              INSTR_W  = 32;
  localparam int              DEPTH    = 2;
  localparam logic [PC_W-1:0] RESET_PC = 36'h100;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt = 1'b0;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               if_valid;
  logic               if_ready = 1'b0;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_dropped;

  fetch_pc_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .perf_fetched  (perf_fetched),
    .perf_dropped  (perf_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    int              epoch;
    int              due;
  } req_t;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } item_t;

  req_t  pend[$];    // memory model: granted requests awaiting response
  item_t exp_q[$];   // scoreboard: instructions decode must receive, in order

  int              tests      = 0;
  int              fails      = 0;
  int              cyc        = 0;
  int              epoch      = 0;
  int              last_due   = 0;
  int              n_fetched  = 0;
  int              n_dropped  = 0;
  int              lat_min    = 1;
  int              lat_max    = 1;
  int              gnt_pct    = 100;
  int              rdy_pct    = 100;
  bit              rst_prev   = 1'b1;
  logic [PC_W-1:0] stream_pc  = RESET_PC;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ {28'h0, a[35:32]} ^ 32'hC0DE_0000;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT's presented outputs against the reference state.
  always @(negedge clk) begin
    automatic int    live = live_count();
    automatic bit    exp_req;
    automatic bit    exp_vld;
    automatic item_t it;
    exp_req = !rst_prev && !redirect_valid &&
              (exp_q.size() + live < DEPTH) && (pend.size() < DEPTH);
    exp_vld = (exp_q.size() != 0) && !redirect_valid;
    check("imem_req", 64'(imem_req), 64'(exp_req));
    check("if_valid", 64'(if_valid), 64'(exp_vld));
    if (rst_prev) begin
      check("reset_imem_addr", 64'(imem_addr), 64'(RESET_PC));
      check("reset_if_pc",     64'(if_pc),     64'h0);
      check("reset_if_instr",  64'(if_instr),  64'h0);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(32'(n_fetched)));
    check("perf_dropped", 64'(perf_dropped), 64'(32'(n_dropped)));
`else
    check("perf_fetched", 64'(perf_fetched), 64'h0);
    check("perf_dropped", 64'(perf_dropped), 64'h0);
`endif
    if (if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: got pc 0x%0h, expected no instruction (cycle %0d)",
                 if_pc, cyc);
      end else begin
        it = exp_q.pop_front();
        check("if_pc",    64'(if_pc),    64'(it.pc));
        check("if_instr", 64'(if_instr), 64'(it.instr));
      end
      n_fetched++;
    end
    rst_prev = rst;
  end

  // Reference model: stream bookkeeping with epochs; a response is kept only
  // if its request belongs to the current stream and no redirect coincides.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      epoch++;
      stream_pc = RESET_PC;
      n_fetched = 0;
      n_dropped = 0;
      last_due  = cyc;
    end else begin
      if (imem_rvalid && pend.size() != 0) begin
        automatic req_t r = pend.pop_front();
        if (redirect_valid || r.epoch != epoch) n_dropped++;
        else exp_q.push_back(item_t'{r.pc, mem_word(r.pc)});
      end
      if (redirect_valid) begin
        epoch++;
        stream_pc = redirect_pc;
        exp_q.delete();
      end
      if (imem_req && imem_gnt) begin
        automatic int due = cyc + int'($urandom_range(lat_max, lat_min));
        check("imem_addr", 64'(imem_addr), 64'(stream_pc));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back(req_t'{stream_pc, epoch, due});
        stream_pc = stream_pc + PC_W'(1);
      end
      tests++;
      if (exp_q.size() + live_count() > DEPTH) begin
        fails++;
        $display("FAIL credit: got %0d buffered+live, expected at most %0d (cycle %0d)",
                 exp_q.size() + live_count(), DEPTH, cyc);
      end
    end
  end

  // Driver: one call per clock cycle.
  task automatic drive(input bit do_rst, input bit do_redir, input logic [PC_W-1:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    rst            = do_rst;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    imem_gnt       = (int'($urandom_range(99, 0)) < gnt_pct);
    if_ready       = (int'($urandom_range(99, 0)) < rdy_pct);
    if (!do_rst && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].pc);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [PC_W-1:0] rpc;

    // Reset, then linear fetch with single-cycle memory.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0);
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    idle(30);

    // Decode backpressure.
    rdy_pct = 0;
    idle(10);
    rdy_pct = 100;
    idle(20);

    // Redirect with slow memory and requests in flight.
    lat_min = 3; lat_max = 3;
    idle(12);
    drive(1'b0, 1'b1, 36'h2000);
    idle(20);

    // Redirect coinciding with a response and a ready decoder.
    lat_min = 1; lat_max = 1;
    idle(10);
    drive(1'b0, 1'b1, 36'h3000);
    idle(10);

    // Back-to-back redirects, then PC wrap.
    drive(1'b0, 1'b1, 36'h40);
    drive(1'b0, 1'b1, 36'h80);
    idle(15);
    drive(1'b0, 1'b1, 36'hF_FFFF_FFFE);
    idle(10);

    // Randomized traffic.
    gnt_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      rpc = {4'($urandom), 32'($urandom)};
      drive(1'b0, ($urandom_range(19, 0) == 0), rpc);
    end

    // Reset during a flush.
    gnt_pct = 100; rdy_pct = 100; lat_min = 4; lat_max = 4;
    idle(8);
    drive(1'b0, 1'b1, 36'h500);
    drive(1'b1, 1'b0, '0);
    lat_min = 1; lat_max = 1;
    idle(25);

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
